swap_arbiter: RTL and testbench

//  Shares one bit-reversal (swap) datapath between two byte requesters.

---
 rtl/swap_arbiter.sv | 125 ++++++++++++
 tb/tb_swap_arbiter.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/swap_arbiter.sv
// rtl/swap_arbiter.sv - two-requester arbiter sharing one bit-reversal unit; define SWAP_ARB_STATS_EN for grant counters
module bit_swap (
    input  logic [7:0] din,
    output logic [7:0] dout
);

    // Mirror the byte: bit i takes bit 7-i.
    always_comb begin
        dout = '0;
        for (int i = 0; i < 8; i++) begin
            dout[i] = din[7-i];
        end
    end

endmodule

module swap_arbiter #(
    parameter int PRIO_FIXED = 0,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [7:0]       req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [7:0]       req1_data,
    output logic             req1_ready,
    output logic             out_valid,
    output logic [7:0]       out_data,
    output logic             out_id,
    input  logic             out_ready,
    output logic [CNT_W-1:0] gnt_cnt0,
    output logic [CNT_W-1:0] gnt_cnt1
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t     state;
    state_t     state_nxt;
    logic       rr_ptr;
    logic       slot_free;
    logic       accept;
    logic       grant;
    logic [7:0] sel_data;
    logic [7:0] swapped;

    // Arbitration: lone requester always wins; contention resolved by rr_ptr or fixed priority.
    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid) begin
            grant = (PRIO_FIXED != 0) ? 1'b0 : rr_ptr;
        end else if (req1_valid) begin
            grant = 1'b1;
        end
        sel_data = grant ? req1_data : req0_data;
    end

    bit_swap u_swap (
        .din  (sel_data),
        .dout (swapped)
    );

    // Slot FSM: next state plus the handshake outputs that depend on it.
    always_comb begin
        state_nxt  = state;
        slot_free  = (state == EMPTY) || out_ready;
        accept     = slot_free && (req0_valid || req1_valid);
        req0_ready = accept && !grant;
        req1_ready = accept && grant;
        case (state)
            EMPTY: if (accept) state_nxt = FULL;
            FULL:  if (out_ready && !accept) state_nxt = EMPTY;
            default: state_nxt = EMPTY;
        endcase
    end

    assign out_valid = (state == FULL);

    // Slot state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Result slot: loaded on every accept, held otherwise (covers stalls).
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data <= 8'h00;
            out_id   <= 1'b0;
        end else if (accept) begin
            out_data <= swapped;
            out_id   <= grant;
        end
    end

    // Round-robin pointer favours the side that lost the last grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= 1'b0;
        end else if (accept && (PRIO_FIXED == 0)) begin
            rr_ptr <= ~grant;
        end
    end

`ifdef SWAP_ARB_STATS_EN
    // Saturating per-side grant counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_cnt0 <= '0;
            gnt_cnt1 <= '0;
        end else if (accept) begin
            if (!grant && (gnt_cnt0 != '1)) gnt_cnt0 <= gnt_cnt0 + CNT_W'(1);
            if (grant && (gnt_cnt1 != '1))  gnt_cnt1 <= gnt_cnt1 + CNT_W'(1);
        end
    end
`else
    assign gnt_cnt0 = '0;
    assign gnt_cnt1 = '0;
`endif

endmodule

// File: tb/tb_swap_arbiter.sv
// tb/tb_swap_arbiter.sv - scoreboard bench for swap_arbiter (round-robin and fixed-priority instances)
module tb_swap_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       r0v [2];
    logic [7:0] r0d [2];
    logic       r0r [2];
    logic       r1v [2];
    logic [7:0] r1d [2];
    logic       r1r [2];
    logic       ov  [2];
    logic [7:0] od  [2];
    logic       oid [2];
    logic       ordy[2];
    logic [1:0] g0  [2];
    logic [1:0] g1  [2];

    logic [8:0] sb0[$];
    logic [8:0] sb1[$];

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    swap_arbiter #(.PRIO_FIXED(0), .CNT_W(2)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(r0v[0]), .req0_data(r0d[0]), .req0_ready(r0r[0]),
        .req1_valid(r1v[0]), .req1_data(r1d[0]), .req1_ready(r1r[0]),
        .out_valid(ov[0]), .out_data(od[0]), .out_id(oid[0]), .out_ready(ordy[0]),
        .gnt_cnt0(g0[0]), .gnt_cnt1(g1[0])
    );

    swap_arbiter #(.PRIO_FIXED(1), .CNT_W(2)) dut_fx (
        .clk(clk), .rst(rst),
        .req0_valid(r0v[1]), .req0_data(r0d[1]), .req0_ready(r0r[1]),
        .req1_valid(r1v[1]), .req1_data(r1d[1]), .req1_ready(r1r[1]),
        .out_valid(ov[1]), .out_data(od[1]), .out_id(oid[1]), .out_ready(ordy[1]),
        .gnt_cnt0(g0[1]), .gnt_cnt1(g1[1])
    );

    task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Monitors: pop the expected result whenever a DUT hands one over.
    always @(negedge clk) begin
        if (!rst && ov[0] && ordy[0]) begin
            if (sb0.size() == 0) check("rr_unexpected_out", {oid[0], od[0]}, 9'h1ff);
            else check("rr_out", {oid[0], od[0]}, sb0.pop_front());
        end
    end

    always @(negedge clk) begin
        if (!rst && ov[1] && ordy[1]) begin
            if (sb1.size() == 0) check("fx_unexpected_out", {oid[1], od[1]}, 9'h1ff);
            else check("fx_out", {oid[1], od[1]}, sb1.pop_front());
        end
    end

    // Called at posedge+1; applies inputs, checks readies mid-cycle, returns at next posedge+1.
    task automatic drive(input int s, input logic v0, input logic [7:0] d0,
                         input logic v1, input logic [7:0] d1, input logic rdy,
                         input logic e0, input logic e1, input logic [7:0] ed);
        r0v[s] = v0; r0d[s] = d0; r1v[s] = v1; r1d[s] = d1; ordy[s] = rdy;
        @(negedge clk);
        check("req0_ready", {8'h0, r0r[s]}, {8'h0, e0});
        check("req1_ready", {8'h0, r1r[s]}, {8'h0, e1});
        if (e0 || e1) begin
            if (s == 0) sb0.push_back({e1, ed});
            else        sb1.push_back({e1, ed});
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input int s);
        drive(s, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic do_reset();
        r0v[0] = 0; r1v[0] = 0; r0v[1] = 0; r1v[1] = 0;
        ordy[0] = 1; ordy[1] = 1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb0.delete();
        sb1.delete();
    endtask

    initial begin
        logic [1:0] exp_cnt;
        for (int s = 0; s < 2; s++) begin
            r0v[s] = 0; r0d[s] = 0; r1v[s] = 0; r1d[s] = 0; ordy[s] = 1;
        end
        do_reset();

        check("reset_out_valid", {8'h0, ov[0]}, 9'h000);
        check("reset_out_data", {1'b0, od[0]}, 9'h000);
        check("reset_out_id", {8'h0, oid[0]}, 9'h000);
        check("reset_gnt_cnt0", {7'h0, g0[0]}, 9'h000);
        check("reset_gnt_cnt1", {7'h0, g1[0]}, 9'h000);

        // Single request from req0, then drain.
        drive(0, 1, 8'h01, 0, 8'h00, 1, 1, 0, 8'h80);
        check("t1_out_valid", {8'h0, ov[0]}, 9'h001);
        idle(0);

        // From reset (rr_ptr was left at 1) both valid: alternate starting with req0.
        do_reset();
        drive(0, 1, 8'h0F, 1, 8'hF0, 1, 1, 0, 8'hF0);
        drive(0, 1, 8'h0F, 1, 8'hF0, 1, 0, 1, 8'h0F);
        drive(0, 1, 8'h0F, 1, 8'hF0, 1, 1, 0, 8'hF0);
        drive(0, 1, 8'h0F, 1, 8'hF0, 1, 0, 1, 8'h0F);
        idle(0);

        // Stall with A5 held, then release: drain and accept in one cycle.
        drive(0, 1, 8'hA5, 0, 8'h00, 1, 1, 0, 8'hA5);
        for (int k = 0; k < 5; k++) begin
            drive(0, 0, 8'h00, 1, 8'h12, 0, 0, 0, 8'h00);
            check("stall_held", {oid[0], od[0]}, 9'h0A5);
            check("stall_valid", {8'h0, ov[0]}, 9'h001);
        end
        drive(0, 0, 8'h00, 1, 8'h12, 1, 0, 1, 8'h48);
        idle(0);

        // Lone req1 is granted even when rr_ptr favours req0.
        drive(0, 0, 8'h00, 1, 8'h01, 1, 0, 1, 8'h80);
        idle(0);

        // Reset while FULL with id1 pending discards it; next contention goes to req0.
        do_reset();
        drive(0, 0, 8'h00, 1, 8'h01, 0, 0, 1, 8'h80);
        check("t5_pending", {oid[0], od[0]}, 9'h180);
        do_reset();
        check("t5_out_valid", {8'h0, ov[0]}, 9'h000);
        check("t5_out_data", {1'b0, od[0]}, 9'h000);
        drive(0, 1, 8'h0F, 1, 8'hF0, 1, 1, 0, 8'hF0);
        idle(0);

        // Fixed priority: req0 wins throughout, req1 only after req0 drops.
        for (int k = 0; k < 4; k++) drive(1, 1, 8'h0F, 1, 8'hF0, 1, 1, 0, 8'hF0);
        drive(1, 0, 8'h00, 1, 8'hF0, 1, 0, 1, 8'h0F);
        idle(1);

        // Grant counters with req1 alone for five grants.
        do_reset();
        for (int k = 0; k < 5; k++) begin
            drive(0, 0, 8'h00, 1, 8'h01 << k, 1, 0, 1, 8'h80 >> k);
`ifdef SWAP_ARB_STATS_EN
            exp_cnt = (k >= 2) ? 2'd3 : 2'(k + 1);
`else
            exp_cnt = 2'd0;
`endif
            check("gnt_cnt1", {7'h0, g1[0]}, {7'h0, exp_cnt});
            check("gnt_cnt0", {7'h0, g0[0]}, 9'h000);
        end
        idle(0);
        idle(0);

        check("sb0_empty", 9'(sb0.size()), 9'h000);
        check("sb1_empty", 9'(sb1.size()), 9'h000);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

endmodule
